// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one sum bit per clock, with IDLE/SHIFT/DONE control
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] rega_q, rega_d;
  logic [WIDTH-1:0] regb_q, regb_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             load, shift, last, s, c_nx;
  logic [WIDTH-1:0] rega_sh;
  // Full-adder slice on the LSBs plus the control decode; the unused state encoding falls back to IDLE
  always_comb begin
    s       = rega_q[0] ^ regb_q[0] ^ carry_q;
    c_nx    = (rega_q[0] & regb_q[0]) | (rega_q[0] & carry_q) | (regb_q[0] & carry_q);
    rega_sh = {s, rega_q[WIDTH-1:1]};
    load    = (state_q == IDLE) && start;
    shift   = state_q == SHIFT;
    last    = count_q == CW'(WIDTH - 1);
    state_d = (state_q == IDLE)  ? (start ? SHIFT : IDLE) :
              (state_q == SHIFT) ? (last ? DONE : SHIFT) : IDLE;
    rega_d  = load ? A : shift ? rega_sh : rega_q;
    regb_d  = load ? B : shift ? {1'b0, regb_q[WIDTH-1:1]} : regb_q;
    carry_d = load ? 1'b0 : shift ? c_nx : carry_q;
    count_d = load ? '0 : shift ? count_q + CW'(1) : count_q;
    sum_d   = (shift && last) ? rega_sh : sum_q;
    cout_d  = (shift && last) ? c_nx : cout_q;
  end
  // All state clears asynchronously on reset so an aborted sum never leaks out
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rega_q  <= '0;
      regb_q  <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rega_q  <= rega_d;
      regb_q  <= regb_d;
      carry_q <= carry_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = state_q == SHIFT;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of the serial adder's timing, results, restart rules and reset abort
module tb_serial_adder;
  logic       Clk, rst, start;
  logic [7:0] A, B, sum;
  logic       cout, busy, done;
  int vectors = 0;
  int miscompares = 0;

  serial_adder #(.WIDTH(8)) dut (
    .Clk(Clk), .rst(rst), .start(start), .A(A), .B(B),
    .sum(sum), .cout(cout), .busy(busy), .done(done)
  );

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  // Called at a negedge; start is accepted on the following posedge (edge 0)
  task automatic run_add(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] es, input logic ec, input string name);
    A = a; B = b; start = 1;
    @(negedge Clk);
    start = 0; A = ~a; B = ~b;
    for (int i = 1; i <= 8; i++) begin
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL %s busy cycle %0d: busy=%b done=%b, want busy=1 done=0", name, i, busy, done);
      end
      @(negedge Clk);
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s done cycle 9: done=%b busy=%b, want done=1 busy=0", name, done, busy);
    end
    vectors++;
    if (sum !== es) begin
      miscompares++;
      $display("FAIL %s sum: got %h want %h", name, sum, es);
    end
    vectors++;
    if (cout !== ec) begin
      miscompares++;
      $display("FAIL %s cout: got %b want %b", name, cout, ec);
    end
    @(negedge Clk);
    vectors++;
    if (done !== 1'b0 || sum !== es || cout !== ec) begin
      miscompares++;
      $display("FAIL %s hold: done=%b sum=%h cout=%b, want done=0 sum=%h cout=%b", name, done, sum, cout, es, ec);
    end
  endtask

  task automatic test_reset();
    rst = 0; start = 0; A = 8'h5C; B = 8'h3E;
    #3;
    vectors++;
    if ({sum, cout, busy, done} !== 11'b0) begin
      miscompares++;
      $display("FAIL reset_async: sum=%h cout=%b busy=%b done=%b, want all 0", sum, cout, busy, done);
    end
    start = 1;
    repeat (3) @(negedge Clk);
    vectors++;
    if ({sum, cout, busy, done} !== 11'b0) begin
      miscompares++;
      $display("FAIL reset_held: sum=%h cout=%b busy=%b done=%b, want all 0", sum, cout, busy, done);
    end
    start = 0; rst = 1;
    @(negedge Clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_results();
    run_add(8'h00, 8'h00, 8'h00, 1'b0, "zero");
    run_add(8'hFF, 8'h01, 8'h00, 1'b1, "ff_01");
    run_add(8'hA5, 8'h5A, 8'hFF, 1'b0, "a5_5a");
    run_add(8'h80, 8'h80, 8'h00, 1'b1, "80_80");
  endtask

  task automatic test_back_to_back();
    int last_done = -1;
    int pulses = 0;
    A = 8'h03; B = 8'h04; start = 1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge Clk);
      if (done === 1'b1) begin
        pulses++;
        vectors++;
        if (sum !== 8'h07 || cout !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b result cycle %0d: sum=%h cout=%b, want 07 0", c, sum, cout);
        end
        vectors++;
        if ((last_done < 0 && c != 9) || (last_done >= 0 && c - last_done != 10)) begin
          miscompares++;
          $display("FAIL b2b spacing: done at cycle %0d, previous %0d, want first at 9 then every 10", c, last_done);
        end
        last_done = c;
      end
    end
    vectors++;
    if (pulses != 4) begin
      miscompares++;
      $display("FAIL b2b pulse count: got %0d want 4", pulses);
    end
    start = 0;
    repeat (12) @(negedge Clk);
  endtask

  task automatic test_ignored_start();
    int first_done = -1;
    int busy_after = 0;
    A = 8'h0F; B = 8'h0F; start = 1;
    @(negedge Clk);
    start = 0; A = 8'h00;
    repeat (2) @(negedge Clk);
    start = 1;
    @(negedge Clk);
    start = 0;
    for (int c = 5; c <= 25; c++) begin
      @(negedge Clk);
      if (first_done >= 0 && busy === 1'b1) busy_after++;
      if (done === 1'b1 && first_done < 0) begin
        first_done = c;
        vectors++;
        if (sum !== 8'h1E || cout !== 1'b0) begin
          miscompares++;
          $display("FAIL ignore result: sum=%h cout=%b, want 1e 0", sum, cout);
        end
      end
    end
    vectors++;
    if (first_done != 9) begin
      miscompares++;
      $display("FAIL ignore done cycle: got %0d want 9", first_done);
    end
    vectors++;
    if (busy_after != 0) begin
      miscompares++;
      $display("FAIL ignore queued: busy after done for %0d cycles, want 0", busy_after);
    end
  endtask

  task automatic test_reset_abort();
    int done_seen = 0;
    run_add(8'hFF, 8'hFF, 8'hFE, 1'b1, "ff_ff");
    A = 8'h12; B = 8'h34; start = 1;
    @(negedge Clk);
    start = 0;
    repeat (3) @(negedge Clk);
    #2 rst = 0;
    #1;
    vectors++;
    if ({sum, cout, busy, done} !== 11'b0) begin
      miscompares++;
      $display("FAIL abort_clear: sum=%h cout=%b busy=%b done=%b, want all 0", sum, cout, busy, done);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge Clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    vectors++;
    if (done_seen != 0) begin
      miscompares++;
      $display("FAIL abort_no_done: done/busy high in %0d cycles, want 0", done_seen);
    end
    rst = 1;
    run_add(8'h21, 8'h43, 8'h64, 1'b0, "after_abort");
  endtask

  initial begin
    test_reset();
    test_results();
    test_back_to_back();
    test_ignored_start();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, want completion");
    $fatal(1);
  end
endmodule
